// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch controller: FSM state encoding, the NOP word
// and the redirect-target selection helper.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT     = 2'd1,
    WAIT_RDR = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // A jump decoded in ID overrides a branch resolved in the same cycle.
  function automatic logic [31:0] redirect_target(input logic        jump,
                                                  input logic [31:0] jump_target,
                                                  input logic [31:0] branch_target);
    return jump ? jump_target : branch_target;
  endfunction

endpackage

// File: rtl/fetch_controller_hazard_detect.sv
// Load-use hazard comparator: flags a load in EX whose destination feeds the
// instruction currently sitting in IF/ID.
module hazard_detect (
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rt,
  input  logic [4:0] IF_ID_Rs,
  input  logic [4:0] IF_ID_Rt,
  output logic       load_use
);

  logic w_rt_nonzero;
  logic w_src_match;

  // Register 0 is hardwired to zero, so a load into it can never create a hazard.
  assign w_rt_nonzero = (ID_EX_Rt != 5'd0);
  assign w_src_match  = (ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt);
  assign load_use     = ID_EX_MemRead && w_rt_nonzero && w_src_match;

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage controller: next-PC select, stall/flush generation around
// load-use hazards, redirects and instruction-memory wait states, with a sticky
// wait-timeout error. Optional perf counters are enabled by FETCH_PERF_CNT_EN.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_OUT_plus4,
  input  logic        imem_ready,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rt,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc_in,
  output logic        HoldPC,
  output logic        Hold_data,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        imem_timeout
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int             CW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  TIMEOUT_SAT = CW'(TIMEOUT);
  localparam bit             TIMEOUT_EN  = (TIMEOUT != 0);

  fetch_state_t  r_state;
  fetch_state_t  w_next_state;
  logic [31:0]   r_pend_target;
  logic          w_pend_load;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_wait_cnt_nxt;
  logic          r_timeout;
  logic          w_load_use;
  logic          w_redirect;
  logic [31:0]   w_target;

  hazard_detect u_hazard_detect (
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_Rt      (ID_EX_Rt),
    .IF_ID_Rs      (IF_ID_Rs),
    .IF_ID_Rt      (IF_ID_Rt),
    .load_use      (w_load_use)
  );

  assign w_redirect = jump || branch_taken;
  assign w_target   = redirect_target(jump, jump_target, branch_target);

  // Outputs are combinational so a stall or redirect takes effect in the same
  // cycle the hazard or memory response is seen.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_next_state = r_state;
    w_pend_load  = 1'b0;
    pc_in        = PC_OUT_plus4;
    HoldPC       = 1'b0;
    Hold_data    = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    if (!rst) begin
      unique case (r_state)
        RUN: begin
          if (w_load_use) begin
            HoldPC       = 1'b1;
            Hold_data    = 1'b1;
            ID_EX_bubble = 1'b1;
          end else if (imem_ready) begin
            if (w_redirect) begin
              pc_in       = w_target;
              IF_ID_flush = 1'b1;
            end
          end else begin
            HoldPC      = 1'b1;
            IF_ID_flush = 1'b1;
            if (w_redirect) begin
              w_pend_load  = 1'b1;
              w_next_state = WAIT_RDR;
            end else begin
              w_next_state = WAIT;
            end
          end
        end
        WAIT: begin
          if (imem_ready) begin
            if (w_redirect) begin
              pc_in       = w_target;
              IF_ID_flush = 1'b1;
            end
            w_next_state = RUN;
          end else begin
            HoldPC      = 1'b1;
            IF_ID_flush = 1'b1;
            if (w_redirect) begin
              w_pend_load  = 1'b1;
              w_next_state = WAIT_RDR;
            end
          end
        end
        WAIT_RDR: begin
          // The word returned here belongs to the abandoned path, so it is always flushed.
          IF_ID_flush = 1'b1;
          if (imem_ready) begin
            pc_in        = r_pend_target;
            w_next_state = RUN;
          end else begin
            HoldPC = 1'b1;
          end
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  always_comb begin
    w_wait_cnt_nxt = r_wait_cnt;
    if (imem_ready) begin
      w_wait_cnt_nxt = '0;
    end else if (r_wait_cnt != TIMEOUT_SAT) begin
      w_wait_cnt_nxt = r_wait_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_state       <= RUN;
      r_pend_target <= NOP_WORD;
      r_wait_cnt    <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_pend_load) begin
        r_pend_target <= w_target;
      end
      if (TIMEOUT_EN && (w_wait_cnt_nxt == TIMEOUT_SAT)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign imem_timeout = r_timeout;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (HoldPC) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (IF_ID_flush) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
